// File: rtl/instr_encoder.sv
// Packs field bundles into MIPS words and streams them into imem at consecutive addresses; optional ENC_CHECKSUM_EN adds an XOR checksum of written words.
// Latency: one registered stage, so a transfer in cycle N produces we/wa/wd in cycle N+1.
// Backpressure: in_ready drops outside LOAD and once DEPTH words are written; an illegal kind parks the FSM in ERR.
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              fin,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [31:0]       wd,
  output logic [ADDR_W:0]   count,
`ifdef ENC_CHECKSUM_EN
  output logic [31:0]       csum,
`endif
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wa_q, wa_d;
  logic [31:0]         wd_q, wd_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic                xfer;
  logic                legal;
  logic [31:0]         word;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state: start overrides everything, an illegal bundle beats fin
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_LOAD;
    end else if (state_q == S_LOAD) begin
      if (xfer && !legal) state_d = S_ERR;
      else if (fin)       state_d = S_DONE;
    end
  end

  // State-derived outputs
  always_comb begin
    busy     = (state_q == S_LOAD);
    in_ready = (state_q == S_LOAD) && (count_q < DEPTH_C);
  end

  always_comb begin
    legal = (kind <= 3'd5);
    xfer  = in_valid && in_ready;
  end

  always_comb begin
    word = 32'h0;
    case (kind)
      3'd0:    word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      3'd1:    word = {OP_LW, rs, rt, imm};
      3'd2:    word = {OP_SW, rs, rt, imm};
      3'd3:    word = {OP_BEQ, rs, rt, imm};
      3'd4:    word = {OP_ADDI, rs, rt, imm};
      3'd5:    word = {OP_J, target};
      default: word = 32'h0;
    endcase
  end

  // The write address is the pre-increment count, so wa never wraps past DEPTH-1
  always_comb begin
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    count_d = count_q;
    err_d   = err_q;
    if (start) begin
      wa_d    = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else if (xfer) begin
      if (legal) begin
        we_d    = 1'b1;
        wa_d    = count_q[ADDR_W-1:0];
        wd_d    = word;
        count_d = count_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= 32'h0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    we    = we_q;
    wa    = wa_q;
    wd    = wd_q;
    count = count_q;
    err   = err_q;
  end

`ifdef ENC_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start)     csum_d = 32'h0;
    else if (we_q) csum_d = csum_q ^ wd_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) csum_q <= 32'h0;
    else          csum_q <= csum_d;
  end

  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vectors plus random bundles checked against an arithmetic encoding model.
module tb_instr_encoder;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              fin = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        kind = '0;
  logic [4:0]        rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]        funct = '0;
  logic [15:0]       imm = '0;
  logic [25:0]       target = '0;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [31:0]       wd;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              err;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]       csum;
`endif

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .fin(fin),
    .in_valid(in_valid), .in_ready(in_ready), .kind(kind),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .target(target), .we(we), .wa(wa), .wd(wd),
    .count(count),
`ifdef ENC_CHECKSUM_EN
    .csum(csum),
`endif
    .busy(busy), .err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoding: opcode value scaled into bits 31:26, fields added at their bit weights
  function automatic logic [31:0] enc_ref(input int k);
    longint unsigned opv;
    longint unsigned w;
    case (k)
      1:       opv = 35;
      2:       opv = 43;
      3:       opv = 4;
      4:       opv = 8;
      5:       opv = 2;
      default: opv = 0;
    endcase
    if (k == 0)
      w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048
        + longint'(shamt) * 64 + longint'(funct);
    else if (k == 5)
      w = opv * 67108864 + longint'(target);
    else
      w = opv * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
    return w[31:0];
  endfunction

  task automatic rand_fields();
    logic [31:0] r;
    r = $urandom; rs = r[4:0]; rt = r[9:5]; rd = r[14:10]; shamt = r[19:15]; funct = r[25:20];
    r = $urandom; imm = r[15:0];
    r = $urandom; target = r[25:0];
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_count = 0;
  endtask

  task automatic rand_xfer(input logic v, input string tag);
    int k;
    int c0;
    logic x;
    logic [31:0] e;
    k = $urandom_range(0, 5);
    rand_fields();
    kind = k[2:0];
    in_valid = v;
    x = v && (exp_count < DEPTH);
    e = enc_ref(k);
    c0 = exp_count;
    step();
    in_valid = 1'b0;
    if (x) exp_count++;
    chk({tag, " we"}, 64'(we), 64'(x));
    if (x) begin
      chk({tag, " wa"}, 64'(wa), 64'(c0));
      chk({tag, " wd"}, 64'(wd), 64'(e));
    end
    chk({tag, " count"}, 64'(count), 64'(exp_count));
  endtask

  initial begin
    logic [31:0] e;
    int c0;

    // Reset state
    step();
    chk("rst we", 64'(we), 0);
    chk("rst wa", 64'(wa), 0);
    chk("rst wd", 64'(wd), 0);
    chk("rst count", 64'(count), 0);
    chk("rst err", 64'(err), 0);
    chk("rst in_ready", 64'(in_ready), 0);
    chk("rst busy", 64'(busy), 0);
    reset_n = 1'b1;
    step();
    chk("idle in_ready", 64'(in_ready), 0);

    do_start();
    chk("start busy", 64'(busy), 1);
    chk("start in_ready", 64'(in_ready), 1);

    // RTYPE add r3,r1,r2
    kind = 3'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd0; funct = 6'h20; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rtype we", 64'(we), 1);
    chk("rtype wa", 64'(wa), 0);
    chk("rtype wd", 64'(wd), 64'h00221820);
    chk("rtype count", 64'(count), 1);
    step();
    chk("pulse we", 64'(we), 0);

    // LW then J back-to-back
    do_start();
    kind = 3'd1; rs = 5'd0; rt = 5'd8; imm = 16'h0004; in_valid = 1'b1;
    step();
    kind = 3'd5; target = 26'h0000010;
    chk("lw we", 64'(we), 1);
    chk("lw wa", 64'(wa), 0);
    chk("lw wd", 64'(wd), 64'h8C080004);
    step();
    in_valid = 1'b0;
    chk("j we", 64'(we), 1);
    chk("j wa", 64'(wa), 1);
    chk("j wd", 64'(wd), 64'h08000010);
    step();
    chk("j after we", 64'(we), 0);

    // Random legal stream with random valid gaps
    do_start();
    for (int i = 0; i < 30; i++) rand_xfer(1'($urandom_range(0, 1)), "rand");

    // fin alongside a legal transfer: word still written, then DONE
    rand_fields();
    kind = 3'd2; in_valid = 1'b1; fin = 1'b1;
    e = enc_ref(2);
    c0 = exp_count;
    step();
    in_valid = 1'b0; fin = 1'b0;
    exp_count++;
    chk("fin we", 64'(we), 1);
    chk("fin wa", 64'(wa), 64'(c0));
    chk("fin wd", 64'(wd), 64'(e));
    chk("fin busy", 64'(busy), 0);
    chk("fin in_ready", 64'(in_ready), 0);
    step();
    chk("done we", 64'(we), 0);
    chk("done count", 64'(count), 64'(exp_count));

    // Illegal kind
    do_start();
    kind = 3'd6; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("illegal err", 64'(err), 1);
    chk("illegal we", 64'(we), 0);
    chk("illegal in_ready", 64'(in_ready), 0);
    chk("illegal busy", 64'(busy), 0);
    chk("illegal count", 64'(count), 0);
    do_start();
    chk("restart err", 64'(err), 0);
    chk("restart wa", 64'(wa), 0);
    chk("restart busy", 64'(busy), 1);

    // Fill all DEPTH words, then one more bundle is refused
    for (int i = 0; i < DEPTH; i++) rand_xfer(1'b1, "fill");
    chk("full count", 64'(count), 64'(DEPTH));
    chk("full in_ready", 64'(in_ready), 0);
    rand_xfer(1'b1, "overflow");
    chk("overflow wa", 64'(wa), 64'(DEPTH - 1));

`ifdef ENC_CHECKSUM_EN
    do_start();
    chk("csum clear", 64'(csum), 0);
    kind = 3'd4; rs = 5'd0; rt = 5'd8; imm = 16'h0005; in_valid = 1'b1;
    step();
    kind = 3'd0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0;
    step();
    in_valid = 1'b0;
    step();
    chk("csum", 64'(csum), 64'h20080005);
`endif

    // Reset mid-stream with a write in flight
    do_start();
    rand_fields();
    kind = 3'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pre-reset we", 64'(we), 1);
    reset_n = 1'b0;
    #1;
    chk("arst we", 64'(we), 0);
    chk("arst wa", 64'(wa), 0);
    chk("arst wd", 64'(wd), 0);
    chk("arst count", 64'(count), 0);
    chk("arst busy", 64'(busy), 0);
    chk("arst in_ready", 64'(in_ready), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
